// File: rtl/dz_pkg.sv
// Shared types and constants for the dz_scan_ctrl LED dot-matrix row scanner.
// Stored row words use the same {red, green} packing as dz_rowdata_t.
package dz_pkg;

    localparam int unsigned DZ_COLS = 8;

    typedef struct packed {
        logic [DZ_COLS-1:0] red;
        logic [DZ_COLS-1:0] green;
    } dz_rowdata_t;

    localparam logic [0:0] DZ_ST_ON  = 1'b0;
    localparam logic [0:0] DZ_ST_GAP = 1'b1;

    typedef enum logic [0:0] {
        DZ_ON  = DZ_ST_ON,
        DZ_GAP = DZ_ST_GAP
    } dz_state_e;

    // Widest supported panel is 16 rows; callers slice to ROWS.
    localparam logic [15:0] DZ_ROW_OFF = '1;

endpackage

// File: rtl/dz_bank_ram.sv
// Two-bank ROWS x (2*COLS) frame store: writes go to the back bank,
// the asynchronous read port always sees the front bank.
module dz_bank_ram #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    localparam int unsigned AW  = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_row,
    input  logic [2*COLS-1:0] wr_data,
    input  logic              swap,
    input  logic [AW-1:0]     rd_row,
    output logic [2*COLS-1:0] rd_data,
    output logic              front
);

    logic [2*COLS-1:0] mem [2][ROWS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[~front][wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front <= 1'b0;
        end else if (swap) begin
            front <= ~front;
        end
    end

    assign rd_data = mem[front][rd_row];

endmodule

// File: rtl/dz_scan_ctrl.sv
// Row-scan driver for bicolour LED dot-matrix panels with double-buffered frames.
// Optional frame-based blinking is enabled by defining DZ_BLINK_EN.
module dz_scan_ctrl
    import dz_pkg::*;
#(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned COLS         = 8,
    parameter int unsigned DWELL        = 1000,
    parameter int unsigned GAP          = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_red,
    input  logic [COLS-1:0]         wr_green,
    input  logic                    swap_req,
    output logic                    swap_ack,
    input  logic                    blank,
    input  logic                    blink,
    output logic                    frame_start,
    output logic [ROWS-1:0]         row,
    output logic [COLS-1:0]         colr,
    output logic [COLS-1:0]         colg
);

    localparam int unsigned AW   = $clog2(ROWS);
    localparam int unsigned CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [AW-1:0] ROW_LAST   = AW'(ROWS - 1);
    localparam logic [AW:0]   ROW_COUNT  = (AW+1)'(ROWS);

    dz_state_e         st;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     next_idx;
    logic              swap_pending;
    logic              on_last;
    logic              gap_last;
    logic              frame_end;
    logic              swap_now;
    logic              wr_en;
    logic              dark;
    logic [2*COLS-1:0] rd_data;
    logic              front;

    assign on_last   = (st == DZ_ON) && (cnt == DWELL_LAST);
    assign gap_last  = (st == DZ_GAP) && (cnt == GAP_LAST);
    assign next_idx  = (idx == ROW_LAST) ? '0 : idx + 1'b1;
    assign frame_end = on_last && (idx == ROW_LAST);
    // A request landing on the boundary itself is honoured immediately.
    assign swap_now  = frame_end && (swap_pending || swap_req);
    assign wr_ready  = ~swap_pending;
    assign wr_en     = wr_valid && wr_ready && ({1'b0, wr_row} < ROW_COUNT);

    dz_bank_ram #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data ({wr_red, wr_green}),
        .swap    (swap_now),
        .rd_row  (idx),
        .rd_data (rd_data),
        .front   (front)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= DZ_ON;
            cnt <= '0;
            idx <= '0;
        end else begin
            case (st)
                DZ_ON: begin
                    if (on_last) begin
                        cnt <= '0;
                        if (GAP == 0) begin
                            idx <= next_idx;
                        end else begin
                            st <= DZ_GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DZ_GAP: begin
                    if (gap_last) begin
                        cnt <= '0;
                        st  <= DZ_ON;
                        idx <= next_idx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= DZ_ON;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            swap_ack <= swap_now;
            if (swap_now) begin
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

`ifdef DZ_BLINK_EN
    localparam int unsigned FW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [FW-1:0] FR_LAST = FW'(2 * BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FR_HALF = FW'(BLINK_FRAMES);

    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_nxt;
    logic          blink_dark;

    always_comb begin
        fcnt_nxt = '0;
        if (blink) begin
            fcnt_nxt = (fcnt == FR_LAST) ? '0 : fcnt + 1'b1;
        end
    end

    // Dark/lit decision only changes at frame boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt       <= '0;
            blink_dark <= 1'b0;
        end else if (frame_end) begin
            fcnt       <= fcnt_nxt;
            blink_dark <= blink && (fcnt_nxt >= FR_HALF);
        end else if (!blink) begin
            fcnt <= '0;
        end
    end

    assign dark = blank | blink_dark;
`else
    logic unused_blink;
    assign unused_blink = blink ^ (BLINK_FRAMES == 0);
    assign dark = blank;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= DZ_ROW_OFF[ROWS-1:0];
            colr        <= '0;
            colg        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (st == DZ_ON) && (idx == '0) && (cnt == '0);
            if ((st == DZ_ON) && !dark) begin
                row  <= ~(ROWS'(1) << idx);
                colr <= rd_data[2*COLS-1:COLS];
                colg <= rd_data[COLS-1:0];
            end else begin
                row  <= DZ_ROW_OFF[ROWS-1:0];
                colr <= '0;
                colg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Scoreboard bench for dz_scan_ctrl: a phase-based panel model queues expected pins per edge.
// Blink checks are compiled in when DZ_BLINK_EN is defined.
module tb_dz_scan_ctrl;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int DWELL  = 4;
    localparam int GAP    = 1;
    localparam int BF     = 2;
    localparam int PER    = DWELL + GAP;
    localparam int FRAME  = ROWS * PER;
    localparam int LAST_S = (ROWS - 1) * PER + DWELL - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic       swap_req = 1'b0;
    logic       blank = 1'b0;
    logic       blink = 1'b0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_red = '0;
    logic [7:0] wr_green = '0;
    logic       wr_ready;
    logic       swap_ack;
    logic       frame_start;
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;

    dz_scan_ctrl #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .DWELL        (DWELL),
        .GAP          (GAP),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_row      (wr_row),
        .wr_red      (wr_red),
        .wr_green    (wr_green),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .blank       (blank),
        .blink       (blink),
        .frame_start (frame_start),
        .row         (row),
        .colr        (colr),
        .colg        (colg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] colr;
        logic [7:0] colg;
        logic       fs;
        logic       ack;
        logic       rdy;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_red [2][ROWS];
    logic [7:0] m_grn [2][ROWS];
    int         m_front;
    int         k;
    int         fcnt;
    bit         m_pend;
    bit         bdark;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROWS; r++) begin
                m_red[b][r] = '0;
                m_grn[b][r] = '0;
            end
        end
        m_front = 0;
        m_pend  = 1'b0;
        k       = 0;
        fcnt    = 0;
        bdark   = 1'b0;
    endtask

    // k counts scan cycles since reset; pins after an edge reflect phase k of the frame.
    task automatic model_step();
        int   s;
        int   r;
        bit   lit;
        bit   dk;
        bit   fend;
        exp_t e;
        s   = k % FRAME;
        r   = s / PER;
        lit = (s % PER) < DWELL;
        dk  = blank;
`ifdef DZ_BLINK_EN
        dk = dk || bdark;
`endif
        e.row  = (lit && !dk) ? ~(8'h01 << r) : 8'hFF;
        e.colr = (lit && !dk) ? m_red[m_front][r] : 8'h00;
        e.colg = (lit && !dk) ? m_grn[m_front][r] : 8'h00;
        e.fs   = (s == 0);
        if (wr_valid && !m_pend && (wr_row < ROWS)) begin
            m_red[1-m_front][wr_row] = wr_red;
            m_grn[1-m_front][wr_row] = wr_green;
        end
        fend  = (s == LAST_S);
        e.ack = fend && (m_pend || swap_req);
        if (e.ack) begin
            m_front = 1 - m_front;
            m_pend  = 1'b0;
        end else if (swap_req) begin
            m_pend = 1'b1;
        end
        e.rdy = !m_pend;
        if (fend) begin
            fcnt  = blink ? (fcnt + 1) % (2 * BF) : 0;
            bdark = blink && (fcnt >= BF);
        end else if (!blink) begin
            fcnt = 0;
        end
        k++;
        sb.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
        end
    end

    int acks_seen = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("row",         row,         e.row);
                check("colr",        colr,        e.colr);
                check("colg",        colg,        e.colg);
                check("frame_start", frame_start, e.fs);
                check("swap_ack",    swap_ack,    e.ack);
                check("wr_ready",    wr_ready,    e.rdy);
                if (swap_ack === 1'b1) acks_seen++;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_phase(input int ph);
        int guard = 0;
        while (((k % FRAME) != ph) && (guard < 2 * FRAME)) begin
            step();
            guard++;
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_row"},         row,         8'hFF);
        check({tag, "_colr"},        colr,        8'h00);
        check({tag, "_colg"},        colg,        8'h00);
        check({tag, "_wr_ready"},    wr_ready,    1'b1);
        check({tag, "_swap_ack"},    swap_ack,    1'b0);
        check({tag, "_frame_start"}, frame_start, 1'b0);
    endtask

    initial begin
        int a0;
        #1 rst = 1'b1;
        #2 check_reset_pins("rst0");
        step(2);
        rst = 1'b0;
        step(45);

        // Row 3 red into back bank, then a swap mid-frame.
        wait_phase(10);
        wr_valid = 1'b1; wr_row = 3'd3; wr_red = 8'h3C; wr_green = 8'h00;
        step();
        wr_valid = 1'b0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        // Write while pending must be dropped.
        step(3);
        wr_valid = 1'b1; wr_row = 3'd5; wr_red = 8'hFF; wr_green = 8'hFF;
        step();
        wr_valid = 1'b0;
        step(90);

        // Write and swap request in the same cycle.
        wait_phase(12);
        wr_valid = 1'b1; wr_row = 3'd0; wr_red = 8'h00; wr_green = 8'h18; swap_req = 1'b1;
        step();
        wr_valid = 1'b0; swap_req = 1'b0;
        step(80);

        // Request exactly on the frame boundary.
        wait_phase(LAST_S);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step(45);

        // Two requests in one frame yield a single swap.
        wait_phase(2);
        a0 = acks_seen;
        swap_req = 1'b1; step(); swap_req = 1'b0;
        step(10);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        step(FRAME);
        check("single_ack", acks_seen - a0, 1);

        blank = 1'b1;
        step(100);
        blank = 1'b0;
        step(10);

        repeat (120) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_row   = 3'($urandom_range(0, 7));
            wr_red   = 8'($urandom);
            wr_green = 8'($urandom);
            swap_req = ($urandom_range(0, 15) == 0);
            blank    = ($urandom_range(0, 9) == 0);
            step();
        end
        wr_valid = 1'b0; swap_req = 1'b0; blank = 1'b0;
        step(45);

        // Reset mid-frame with a swap pending.
        wait_phase(7);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        step(3);
        rst = 1'b1;
        #1 check_reset_pins("rst_mid");
        step(3);
        rst = 1'b0;
        step(45);

`ifdef DZ_BLINK_EN
        blink = 1'b1;
        step(5 * FRAME);
        wait_phase(20);
        rst = 1'b1;
        #1 check_reset_pins("rst_blink");
        step(2);
        rst = 1'b0;
        step(5 * FRAME);
        blink = 1'b0;
        step(2 * FRAME);
`endif

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dz_scan_ctrl.md
Name: dz_scan_ctrl

Overview:
Parametrised row-scan driver for bicolour (red/green) LED dot-matrix panels. Holds two frame buffers: the front bank is scanned to the panel while the back bank accepts row writes through a valid/ready port. A swap request exchanges the banks, but only at a frame boundary, so the panel never shows a torn image. A programmable dead-time between rows suppresses ghosting. Sits between the digit/glyph generators and the panel pins, replacing per-digit hard-coded scanners.

Parameters:
ROWS, 8, number of panel rows scanned (2..16)
COLS, 8, columns per colour plane
DWELL, 1000, clk cycles each row is lit (>=1)
GAP, 2, clk cycles of dead-time between rows, all rows off (>=0)
BLINK_FRAMES, 64, frames per blink half-period (used only with DZ_BLINK_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  back-bank write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_row  in  $clog2(ROWS)  back-bank row address
wr_red  in  COLS  red pixel data for wr_row
wr_green  in  COLS  green pixel data for wr_row
swap_req  in  1  one-cycle pulse requesting a bank swap
swap_ack  out  1  one-cycle pulse on the cycle the banks exchange
blank  in  1  level; forces the panel dark while scanning continues
blink  in  1  level; enables blinking (DZ_BLINK_EN only)
frame_start  out  1  one-cycle pulse when row 0 begins its dwell
row  out  ROWS  active-low row select, one-hot-zero
colr  out  COLS  red column drive, active-high
colg  out  COLS  green column drive, active-high

Behaviour:
- Reset values:
  - row = all ones; colr = colg = 0.
  - wr_ready = 1; swap_ack = 0; frame_start = 0.
  - Both banks cleared to 0; front bank = bank 0; row index = 0; scan FSM in ON with dwell counter 0.
- Scan FSM has two states:
  - ON: counts DWELL cycles, then goes to GAP. If GAP = 0, it goes directly to ON of the next row.
  - GAP: counts GAP cycles, then goes to ON with row index + 1.
  - Row index wraps from ROWS-1 to 0.
  - A frame boundary is the ON->next transition taken from row ROWS-1.
- Output pipeline:
  - row, colr and colg are registered from FSM state with 1-cycle latency, and all three update on the same edge.
  - In ON: row has bit[idx] = 0; colr/colg come from the front bank at row idx.
  - In GAP, or when blank = 1: row = all ones, colr = colg = 0.
- frame_start pulses for one cycle, aligned with the first pin cycle of row 0 in ON.
- Write port:
  - A write is accepted on the edge where wr_valid && wr_ready.
  - wr_red/wr_green go to the back bank at wr_row.
  - wr_row >= ROWS: the handshake is accepted, the data is dropped.
- Swap:
  - A swap_req while idle sets swap_pending, and wr_ready drops to 0 on the next cycle.
  - At the next frame boundary, front/back toggle, swap_ack pulses, swap_pending clears and wr_ready returns to 1.
  - If the request arrives exactly at a frame boundary, the swap takes effect at that same boundary.
  - A swap_req while pending is ignored (no queueing).
  - No copy is made on swap: the new back bank holds the old front image.
- Simultaneous events:
  - wr_valid and swap_req in the same cycle with wr_ready = 1: the write completes to the current back bank, then the swap goes pending.
  - blank has no effect on counters, swap timing or frame_start.
- Reset asserted mid-frame or mid-swap returns immediately to the reset state; any pending swap is lost.

Optional Feature:
DZ_BLINK_EN
- Defined:
  - A frame counter of width $clog2(BLINK_FRAMES) + 1 increments at each frame boundary.
  - While blink = 1, the panel is forced dark during the odd half-period (BLINK_FRAMES frames off, BLINK_FRAMES frames on).
  - Blanking is applied at frame boundaries only.
  - While blink = 0, the counter is held at 0.
- Undefined: the blink port is present but ignored, the counter logic is absent, and the panel is never blink-blanked.

Decomposition:
- Package dz_pkg:
  - typedef dz_rowdata_t (struct of COLS red + COLS green bits).
  - scan-state enum {DZ_ON, DZ_GAP}.
  - localparam DZ_ROW_OFF (all ones).
- Sub-module dz_bank_ram: a 2-bank ROWS x (2*COLS) register file with
  - one write port targeting !front;
  - one asynchronous read port targeting front;
  - the front-select flop.
- dz_scan_ctrl contains the FSM, counters, swap logic and output registers.

Test Plan:
- Reset, then idle (DWELL=4, GAP=1, ROWS=8): row cycles 11111110 -> 11111111 -> 11111101 ...; each row stays low 4 cycles; frame period 40 cycles; colr = colg = 0.
- Write row 3 red = 8'h3C, then pulse swap_req: wr_ready = 0 until frame end; swap_ack pulses once at the boundary; next frame shows colr = 8'h3C only while row = 11110111.
- Write and swap_req in the same cycle (row 0 green = 8'h18): the write lands in the old back bank; after the swap the panel shows colg = 8'h18 on row 0.
- swap_req issued twice within a frame: exactly one swap_ack; wr_ready returns to 1 after the boundary.
- blank held high for 100 cycles: row = 8'hFF and colr = colg = 0 throughout; frame_start is still periodic every 40 cycles.
- DZ_BLINK_EN defined with BLINK_FRAMES = 2 and blink = 1: the pattern is 2 frames dark, 2 frames lit, repeating; rst mid-blink returns to all-dark reset outputs and restarts.
